// File: rtl/reduce_unit.sv
// reduce_unit: folds an N-bit operand K bits per cycle into a one-bit AND/OR/XOR/NAND reduction
module reduce_unit #(
   parameter int N = 8,
   parameter int K = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in_data,
   input  logic [1:0]   op,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy
);
   localparam int C = (N + K - 1) / K;
   localparam int CW = $clog2(C) + 1;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state_q, state_d;
   logic [N-1:0] data_q, data_d;
   logic [1:0] op_q, op_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic acc_q, acc_d;
   logic in_ready_q, in_ready_d;
   logic busy_q, busy_d;
   logic out_valid_q, out_valid_d;
   logic out_data_q, out_data_d;
   logic ident;
   logic [C*K-1:0] padded;
   logic [K-1:0] chunk;
   logic fold;
   // bits past N in the last chunk read as the identity so they never change the result
   always_comb begin
      ident = ~(op_q[1] ^ op_q[0]);
      padded = {(C*K){ident}};
      padded[N-1:0] = data_q;
      chunk = K'(padded >> (int'(cnt_q) * K));
      fold = op_q == 2'b01 ? acc_q | (|chunk) : op_q == 2'b10 ? acc_q ^ (^chunk) : acc_q & (&chunk);
   end
   always_comb begin
      state_d = state_q;
      data_d = data_q;
      op_d = op_q;
      cnt_d = cnt_q;
      acc_d = acc_q;
      if (state_q == IDLE && in_valid) begin
         state_d = BUSY;
         data_d = in_data;
         op_d = op;
         cnt_d = '0;
         acc_d = ~(op[1] ^ op[0]);
      end else if (state_q == BUSY) begin
         acc_d = fold;
         cnt_d = cnt_q + CW'(1);
         state_d = cnt_q == CW'(C - 1) ? DONE : BUSY;
      end else if (state_q == DONE && out_ready) begin
         state_d = IDLE;
      end
      in_ready_d = state_d == IDLE;
      busy_d = state_d == BUSY;
      out_valid_d = state_d == DONE;
      out_data_d = state_d == DONE && (op_d == 2'b11 ? ~acc_d : acc_d);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q <= '0;
         op_q <= '0;
         cnt_q <= '0;
         acc_q <= 1'b0;
         in_ready_q <= 1'b1;
         busy_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q <= data_d;
         op_q <= op_d;
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         in_ready_q <= in_ready_d;
         busy_q <= busy_d;
         out_valid_q <= out_valid_d;
         out_data_q <= out_data_d;
      end
   end
   assign in_ready = in_ready_q;
   assign busy = busy_q;
   assign out_valid = out_valid_q;
   assign out_data = out_data_q;
endmodule

// File: doc/reduce_unit.md
REDUCE_UNIT -- requirements
Module: reduce_unit

Interface
REQ-001 Parameter N, default 8, input vector width; SHALL be >= 2.
REQ-002 Parameter K, default 3, bits folded per cycle; SHALL satisfy 1 <= K <= N.
REQ-003 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset sampled on the rising clk edge.
REQ-005 Port in_data, input, N, operand vector.
REQ-006 Port op, input, 2, operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-007 Port in_valid, input, 1, operand and op present.
REQ-008 Port in_ready, output, 1, unit can accept an operand.
REQ-009 Port out_data, output, 1, reduction result.
REQ-010 Port out_valid, output, 1, out_data is valid.
REQ-011 Port out_ready, input, 1, consumer accepts the result.
REQ-012 Port busy, output, 1, high while state is BUSY.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and DONE, with an internal chunk counter of width clog2(C)+1, where C = ceil(N/K).
REQ-014 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in BUSY; out_valid SHALL be 1 only in DONE.
REQ-015 In IDLE, when in_valid & in_ready is sampled (the accept edge), the unit SHALL latch in_data and op, clear the counter, preset the accumulator to the identity element (1 for AND/NAND, 0 for OR/XOR), and go to BUSY.
REQ-016 In IDLE, when in_valid is low, the unit SHALL stay in IDLE with all registers unchanged.
REQ-017 In BUSY, each edge SHALL fold chunk j = bits [j*K +: K] into the accumulator with the latched op's base function (AND, OR or XOR), then increment j.
REQ-018 Bits of the final chunk at or above index N SHALL be replaced by the identity element.
REQ-019 After the edge that folds chunk C-1, the state SHALL become DONE, so out_valid rises exactly C cycles after the accept edge.
REQ-020 For NAND, out_data SHALL be the inverse of the AND accumulation; for all other ops it SHALL equal the accumulator.
REQ-021 out_data SHALL be held stable for the whole time out_valid is high.
REQ-022 In DONE, out_valid & out_ready SHALL return the unit to IDLE on that edge; with out_ready low, the unit SHALL stay in DONE indefinitely.
REQ-023 in_data and op changes after the accept edge SHALL NOT affect the result in progress.
REQ-024 When K = N, C SHALL equal 1, giving a one-cycle BUSY phase.
REQ-025 A new operand SHALL be accepted no earlier than the cycle after the DONE-to-IDLE handshake; back-to-back throughput is one result per C+2 cycles.

Reset
REQ-026 rst high SHALL force the state to IDLE, the counter to 0, the accumulator to 0, out_data to 0, out_valid to 0, busy to 0 and in_ready to 1 on the next edge.
REQ-027 rst SHALL take priority over every handshake, including in_valid or out_ready asserted on the same edge.
REQ-028 A reset asserted during BUSY or DONE SHALL discard the operation in progress without producing out_valid.
REQ-029 The first accept after reset is released SHALL be the first rising edge with rst low and in_valid high.

Verification
REQ-030 With N=8, K=3, op=00, in_data=8'hFF, accept at edge E0 -> busy high for 3 cycles; out_valid=1 and out_data=1 after edge E3.
REQ-031 With N=8, K=3, op=00, in_data=8'hFE -> out_data=0; with op=11, in_data=8'hFF -> out_data=0; with op=11, in_data=8'h7F -> out_data=1.
REQ-032 With N=8, K=3, op=10, in_data=8'b1011_0001 -> out_data=0; with in_data=8'b1011_0011 -> out_data=1; with op=01, in_data=8'h00 -> out_data=0; with op=01, in_data=8'h80 -> out_data=1. These values exercise padding of the last chunk.
REQ-033 Backpressure: out_ready held low for 5 cycles after out_valid rises -> out_valid and out_data stable and in_ready=0 throughout; out_ready=1 -> IDLE on the next edge and in_ready=1.
REQ-034 Reset mid-operation: rst high for 1 cycle during the second BUSY cycle -> IDLE after that edge, out_valid never asserts for that operand, and the next operand 8'hFF with op=00 yields out_data=1 with the normal 3-cycle latency.
REQ-035 The bench SHALL also run N=8, K=8, op=01, in_data=8'h10 -> out_data=1, with out_valid 1 cycle after accept, and a randomized run of at least 1000 operands per op checked against a reference reduction model.
